// File: rtl/mem_port_arb_if.sv
`default_nettype none
// ============================================================================
// mem_port_arb_if
// Instruction, data and memory request/response bundle for mem_port_arb.
// Revision: 1.0
// ============================================================================
interface mem_port_arb_if;
    // core instruction request / response
    logic        ireqready_o;
    logic        ireqvalid_i;
    logic [1:0]  ireqhpl_i;
    logic [31:0] ireqaddr_i;
    logic        irspready_i;
    logic        irspvalid_o;
    logic        irsprerr_o;
    logic [31:0] irspdata_o;
    // core data request / response
    logic        dreqready_o;
    logic        dreqvalid_i;
    logic [1:0]  dreqsize_i;
    logic        dreqdvalid_i;
    logic [1:0]  dreqhpl_i;
    logic [31:0] dreqaddr_i;
    logic [31:0] dreqdata_i;
    logic        drspready_i;
    logic        drspvalid_o;
    logic        drsprerr_o;
    logic        drspwerr_o;
    logic [31:0] drspdata_o;
    // memory request / response
    logic        mreqready_i;
    logic        mreqvalid_o;
    logic [1:0]  mreqsize_o;
    logic        mreqdvalid_o;
    logic [1:0]  mreqhpl_o;
    logic [31:0] mreqaddr_o;
    logic [31:0] mreqdata_o;
    logic        mrspready_o;
    logic        mrspvalid_i;
    logic        mrsprerr_i;
    logic        mrspwerr_i;
    logic [31:0] mrspdata_i;

    modport slave (
        output ireqready_o, input  ireqvalid_i, ireqhpl_i, ireqaddr_i,
        input  irspready_i, output irspvalid_o, irsprerr_o, irspdata_o,
        output dreqready_o, input  dreqvalid_i, dreqsize_i, dreqdvalid_i,
        input  dreqhpl_i, dreqaddr_i, dreqdata_i,
        input  drspready_i, output drspvalid_o, drsprerr_o, drspwerr_o, drspdata_o,
        input  mreqready_i, output mreqvalid_o, mreqsize_o, mreqdvalid_o,
        output mreqhpl_o, mreqaddr_o, mreqdata_o,
        output mrspready_o, input  mrspvalid_i, mrsprerr_i, mrspwerr_i, mrspdata_i
    );

    modport master (
        input  ireqready_o, output ireqvalid_i, ireqhpl_i, ireqaddr_i,
        output irspready_i, input  irspvalid_o, irsprerr_o, irspdata_o,
        input  dreqready_o, output dreqvalid_i, dreqsize_i, dreqdvalid_i,
        output dreqhpl_i, dreqaddr_i, dreqdata_i,
        output drspready_i, input  drspvalid_o, drsprerr_o, drspwerr_o, drspdata_o,
        output mreqready_i, input  mreqvalid_o, mreqsize_o, mreqdvalid_o,
        input  mreqhpl_o, mreqaddr_o, mreqdata_o,
        input  mrspready_o, output mrspvalid_i, mrsprerr_i, mrspwerr_i, mrspdata_i
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arb.sv
`default_nettype none
// ============================================================================
// mem_port_arb
// Merges instruction and data ports onto one memory port; a routing FIFO of
// source IDs steers in-order responses back. MERLIN_ARB_DPRIO_EN selects
// fixed data-over-instruction priority instead of round-robin.
// Revision: 1.0
// ============================================================================
module mem_port_arb #(
    parameter int C_FIFO_DEPTH_X = 2
) (
    input  logic          clk_i,
    input  logic          resetb_i,
    input  logic          clk_en_i,
    mem_port_arb_if.slave bus
);

    localparam int DEPTH = 2 ** C_FIFO_DEPTH_X;
    localparam logic [C_FIFO_DEPTH_X:0] FULL_CNT = {1'b1, {C_FIFO_DEPTH_X{1'b0}}};

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_e;

    src_e                      last_q, last_d;
    src_e                      lock_src_q, lock_src_d;
    logic                      lock_q, lock_d;
    logic [DEPTH-1:0]          id_mem_q, id_mem_d;
    logic [C_FIFO_DEPTH_X-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_FIFO_DEPTH_X-1:0] rd_ptr_q, rd_ptr_d;
    logic [C_FIFO_DEPTH_X:0]   count_q, count_d;

    src_e gnt;
    src_e head_src;
    logic fifo_full;
    logic fifo_empty;
    logic src_valid;
    logic req_valid;
    logic req_fire;
    logic route_i;
    logic route_d;
    logic rsp_ready;
    logic rsp_fire;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);

    // Grant: a stalled request keeps its source until accepted
    always_comb begin
        gnt = SRC_I;
        if (lock_q) begin
            gnt = lock_src_q;
        end
`ifdef MERLIN_ARB_DPRIO_EN
        else if (bus.dreqvalid_i) begin
            gnt = SRC_D;
        end
`else
        else if (bus.ireqvalid_i && bus.dreqvalid_i) begin
            gnt = (last_q == SRC_D) ? SRC_I : SRC_D;
        end
        else if (bus.dreqvalid_i) begin
            gnt = SRC_D;
        end
`endif
    end

    assign src_valid = (gnt == SRC_D) ? bus.dreqvalid_i : bus.ireqvalid_i;
    assign req_valid = resetb_i && !fifo_full && src_valid;
    assign req_fire  = clk_en_i && req_valid && bus.mreqready_i;

    assign bus.mreqvalid_o  = req_valid;
    assign bus.ireqready_o  = resetb_i && !fifo_full && (gnt == SRC_I) && bus.mreqready_i;
    assign bus.dreqready_o  = resetb_i && !fifo_full && (gnt == SRC_D) && bus.mreqready_i;
    assign bus.mreqsize_o   = (gnt == SRC_D) ? bus.dreqsize_i   : 2'b10;
    assign bus.mreqdvalid_o = (gnt == SRC_D) ? bus.dreqdvalid_i : 1'b0;
    assign bus.mreqhpl_o    = (gnt == SRC_D) ? bus.dreqhpl_i    : bus.ireqhpl_i;
    assign bus.mreqaddr_o   = (gnt == SRC_D) ? bus.dreqaddr_i   : bus.ireqaddr_i;
    assign bus.mreqdata_o   = (gnt == SRC_D) ? bus.dreqdata_i   : 32'h0;

    // Response routing follows the oldest outstanding request
    assign head_src  = src_e'(id_mem_q[rd_ptr_q]);
    assign route_i   = resetb_i && !fifo_empty && (head_src == SRC_I);
    assign route_d   = resetb_i && !fifo_empty && (head_src == SRC_D);
    assign rsp_ready = route_i ? bus.irspready_i :
                       route_d ? bus.drspready_i : 1'b1;
    assign rsp_fire  = clk_en_i && (route_i || route_d) && bus.mrspvalid_i && rsp_ready;

    assign bus.mrspready_o = rsp_ready;
    assign bus.irspvalid_o = route_i && bus.mrspvalid_i;
    assign bus.drspvalid_o = route_d && bus.mrspvalid_i;
    assign bus.irsprerr_o  = route_i && bus.mrsprerr_i;
    assign bus.drsprerr_o  = route_d && bus.mrsprerr_i;
    assign bus.drspwerr_o  = route_d && bus.mrspwerr_i;
    assign bus.irspdata_o  = bus.mrspdata_i;
    assign bus.drspdata_o  = bus.mrspdata_i;

    always_comb begin
        last_d     = last_q;
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        id_mem_d   = id_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (clk_en_i) begin
            lock_d     = req_valid && !bus.mreqready_i;
            lock_src_d = gnt;
            if (req_fire) begin
                last_d             = gnt;
                id_mem_d[wr_ptr_q] = gnt;
                wr_ptr_d           = wr_ptr_q + 1'b1;
            end
            if (rsp_fire) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({req_fire, rsp_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            last_q     <= SRC_D;
            lock_q     <= 1'b0;
            lock_src_q <= SRC_I;
            id_mem_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            last_q     <= last_d;
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
            id_mem_q   <= id_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arb.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arb
// Directed stimulus for mem_port_arb with a queue-based reference model.
// Revision: 1.0
// ============================================================================
module tb_mem_port_arb;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic resetb;
    logic clk_en;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_port_arb_if bus ();

    mem_port_arb #(.C_FIFO_DEPTH_X(2)) dut (
        .clk_i    (clk),
        .resetb_i (resetb),
        .clk_en_i (clk_en),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding sources as a queue, 0=I 1=D
    int q[$];
    int last_g = 1;
    bit lock_v = 1'b0;
    int lock_s = 0;
    int g;
    int head;
    bit ev;
    bit e_mrr;

    always @(negedge clk) begin
        if (!resetb) begin
            q.delete();
            last_g = 1;
            lock_v = 1'b0;
            check("rst_mreqvalid", bus.mreqvalid_o, 0);
            check("rst_ireqready", bus.ireqready_o, 0);
            check("rst_dreqready", bus.dreqready_o, 0);
            check("rst_irspvalid", bus.irspvalid_o, 0);
            check("rst_drspvalid", bus.drspvalid_o, 0);
            check("rst_mrspready", bus.mrspready_o, 1);
        end else begin
            if (lock_v) g = lock_s;
`ifdef MERLIN_ARB_DPRIO_EN
            else g = bus.dreqvalid_i ? 1 : 0;
`else
            else if (bus.ireqvalid_i && bus.dreqvalid_i) g = (last_g + 1) % 2;
            else g = bus.dreqvalid_i ? 1 : 0;
`endif
            ev = (q.size() < DEPTH) && (g == 1 ? bus.dreqvalid_i : bus.ireqvalid_i);
            check("m_mreqvalid", bus.mreqvalid_o, ev);
            check("m_ireqready", bus.ireqready_o, (q.size() < DEPTH) && g == 0 && bus.mreqready_i);
            check("m_dreqready", bus.dreqready_o, (q.size() < DEPTH) && g == 1 && bus.mreqready_i);
            if (ev) begin
                check("m_mreqsize",   bus.mreqsize_o,   g == 1 ? bus.dreqsize_i   : 2'b10);
                check("m_mreqdvalid", bus.mreqdvalid_o, g == 1 ? bus.dreqdvalid_i : 1'b0);
                check("m_mreqhpl",    bus.mreqhpl_o,    g == 1 ? bus.dreqhpl_i    : bus.ireqhpl_i);
                check("m_mreqaddr",   bus.mreqaddr_o,   g == 1 ? bus.dreqaddr_i   : bus.ireqaddr_i);
                check("m_mreqdata",   bus.mreqdata_o,   g == 1 ? bus.dreqdata_i   : 32'h0);
            end
            head  = (q.size() > 0) ? q[0] : -1;
            e_mrr = (head == 0) ? bus.irspready_i : (head == 1) ? bus.drspready_i : 1'b1;
            check("m_mrspready", bus.mrspready_o, e_mrr);
            check("m_irspvalid", bus.irspvalid_o, head == 0 && bus.mrspvalid_i);
            check("m_drspvalid", bus.drspvalid_o, head == 1 && bus.mrspvalid_i);
            check("m_irsprerr",  bus.irsprerr_o,  head == 0 && bus.mrsprerr_i);
            check("m_drsprerr",  bus.drsprerr_o,  head == 1 && bus.mrsprerr_i);
            check("m_drspwerr",  bus.drspwerr_o,  head == 1 && bus.mrspwerr_i);
            check("m_irspdata",  bus.irspdata_o,  bus.mrspdata_i);
            check("m_drspdata",  bus.drspdata_o,  bus.mrspdata_i);
            if (clk_en) begin
                if (ev && bus.mreqready_i) begin
                    q.push_back(g);
                    last_g = g;
                end
                lock_v = ev && !bus.mreqready_i;
                lock_s = g;
                if (head >= 0 && bus.mrspvalid_i && e_mrr) void'(q.pop_front());
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        bus.mrspvalid_i = 1'b1;
        repeat (n) next_cycle();
        bus.mrspvalid_i = 1'b0;
    endtask

    logic [31:0] exp_addr [4];
    bit          exp_i    [4];

    initial begin
        resetb = 1'b0;
        clk_en = 1'b1;
        bus.ireqvalid_i = 1'b1;  bus.ireqhpl_i = 2'd1;  bus.ireqaddr_i = 32'h1000;
        bus.irspready_i = 1'b1;
        bus.dreqvalid_i = 1'b0;  bus.dreqsize_i = 2'd1; bus.dreqdvalid_i = 1'b1;
        bus.dreqhpl_i = 2'd2;    bus.dreqaddr_i = 32'h2000; bus.dreqdata_i = 32'hA5A5A5A5;
        bus.drspready_i = 1'b1;
        bus.mreqready_i = 1'b1;
        bus.mrspvalid_i = 1'b0;  bus.mrsprerr_i = 1'b0; bus.mrspwerr_i = 1'b0;
        bus.mrspdata_i = 32'h0;

        // reset gates outputs even with a pending request
        @(negedge clk);
        check("reset_mreqvalid", bus.mreqvalid_o, 0);
        check("reset_ireqready", bus.ireqready_o, 0);
        check("reset_mrspready", bus.mrspready_o, 1);
        next_cycle();
        resetb = 1'b1;

        // both valid each cycle until full
`ifdef MERLIN_ARB_DPRIO_EN
        exp_addr = '{32'h2000, 32'h2000, 32'h2000, 32'h2000};
        exp_i    = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_addr = '{32'h1000, 32'h2000, 32'h1000, 32'h2000};
        exp_i    = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif
        bus.dreqvalid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("alt_grant_addr", bus.mreqaddr_o, exp_addr[k]);
            next_cycle();
        end
        @(negedge clk);
        check("full_mreqvalid", bus.mreqvalid_o, 0);
        check("full_ireqready", bus.ireqready_o, 0);
        check("full_dreqready", bus.dreqready_o, 0);
        next_cycle();
        bus.ireqvalid_i = 1'b0;
        bus.dreqvalid_i = 1'b0;
        bus.mrspvalid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.mrspdata_i = 32'h100 + k;
            @(negedge clk);
            check("alt_rsp_irspvalid", bus.irspvalid_o, exp_i[k]);
            check("alt_rsp_drspvalid", bus.drspvalid_o, !exp_i[k]);
            next_cycle();
        end
        bus.mrspvalid_i = 1'b0;

        // stalled D request holds the grant
        bus.dreqvalid_i = 1'b1; bus.dreqaddr_i = 32'h100; bus.dreqdvalid_i = 1'b0;
        bus.mreqready_i = 1'b0;
        @(negedge clk);
        check("lock_addr_a", bus.mreqaddr_o, 32'h100);
        next_cycle();
        bus.ireqvalid_i = 1'b1; bus.ireqaddr_i = 32'h3000;
        repeat (2) begin
            @(negedge clk);
            check("lock_addr_held", bus.mreqaddr_o, 32'h100);
            check("lock_ireqready", bus.ireqready_o, 0);
            next_cycle();
        end
        bus.mreqready_i = 1'b1;
        @(negedge clk);
        check("lock_release_addr", bus.mreqaddr_o, 32'h100);
        check("lock_dreqready", bus.dreqready_o, 1);
        next_cycle();
        @(negedge clk);
`ifdef MERLIN_ARB_DPRIO_EN
        check("after_lock_addr", bus.mreqaddr_o, 32'h100);
`else
        check("after_lock_addr", bus.mreqaddr_o, 32'h3000);
`endif
        next_cycle();
        bus.ireqvalid_i = 1'b0; bus.dreqvalid_i = 1'b0;
        drain(2);

        // fill with instruction requests, pop does not unblock the same cycle
        bus.ireqvalid_i = 1'b1; bus.ireqaddr_i = 32'h4000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("fill_ireqready", bus.ireqready_o, 1);
            next_cycle();
        end
        @(negedge clk);
        check("fifth_ireqready", bus.ireqready_o, 0);
        check("fifth_mreqvalid", bus.mreqvalid_o, 0);
        next_cycle();
        bus.mrspvalid_i = 1'b1;
        @(negedge clk);
        check("pop_cycle_ireqready", bus.ireqready_o, 0);
        check("pop_cycle_irspvalid", bus.irspvalid_o, 1);
        next_cycle();
        bus.mrspvalid_i = 1'b0;
        @(negedge clk);
        check("after_pop_ireqready", bus.ireqready_o, 1);
        next_cycle();
        bus.ireqvalid_i = 1'b0;
        drain(4);

        // I then D outstanding, D response back-pressured
        bus.ireqvalid_i = 1'b1;
        next_cycle();
        bus.ireqvalid_i = 1'b0; bus.dreqvalid_i = 1'b1;
        next_cycle();
        bus.dreqvalid_i = 1'b0;
        bus.mrspvalid_i = 1'b1; bus.mrspdata_i = 32'h11111111;
        @(negedge clk);
        check("rsp_i_irspvalid", bus.irspvalid_o, 1);
        check("rsp_i_irspdata", bus.irspdata_o, 32'h11111111);
        next_cycle();
        bus.drspready_i = 1'b0; bus.mrspdata_i = 32'hDEADBEEF;
        bus.mrsprerr_i = 1'b1; bus.mrspwerr_i = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rsp_d_mrspready", bus.mrspready_o, 0);
            check("rsp_d_drspvalid", bus.drspvalid_o, 1);
            check("rsp_d_irspvalid", bus.irspvalid_o, 0);
            check("rsp_d_drspdata", bus.drspdata_o, 32'hDEADBEEF);
            check("rsp_d_drsprerr", bus.drsprerr_o, 1);
            check("rsp_d_irsprerr", bus.irsprerr_o, 0);
            next_cycle();
        end
        bus.drspready_i = 1'b1;
        @(negedge clk);
        check("rsp_d_release", bus.mrspready_o, 1);
        next_cycle();
        bus.mrsprerr_i = 1'b0; bus.mrspwerr_i = 1'b0;

        // response with nothing outstanding is discarded
        bus.drspready_i = 1'b0; bus.irspready_i = 1'b0;
        @(negedge clk);
        check("empty_mrspready", bus.mrspready_o, 1);
        check("empty_irspvalid", bus.irspvalid_o, 0);
        check("empty_drspvalid", bus.drspvalid_o, 0);
        next_cycle();
        bus.mrspvalid_i = 1'b0;
        bus.drspready_i = 1'b1; bus.irspready_i = 1'b1;

        // clock enable low: no request is recorded
        clk_en = 1'b0; bus.ireqvalid_i = 1'b1;
        @(negedge clk);
        check("clken_mreqvalid", bus.mreqvalid_o, 1);
        next_cycle();
        clk_en = 1'b1; bus.ireqvalid_i = 1'b0; bus.mrspvalid_i = 1'b1;
        @(negedge clk);
        check("clken_no_push", bus.irspvalid_o, 0);
        next_cycle();
        bus.mrspvalid_i = 1'b0;

        // reset with two outstanding requests
        bus.ireqvalid_i = 1'b1;
        repeat (2) next_cycle();
        resetb = 1'b0;
        @(negedge clk);
        check("midrst_mreqvalid", bus.mreqvalid_o, 0);
        check("midrst_mrspready", bus.mrspready_o, 1);
        next_cycle();
        resetb = 1'b1; bus.ireqvalid_i = 1'b0; bus.mrspvalid_i = 1'b1;
        @(negedge clk);
        check("postrst_irspvalid", bus.irspvalid_o, 0);
        check("postrst_mrspready", bus.mrspready_o, 1);
        next_cycle();
        bus.mrspvalid_i = 1'b0;
        bus.ireqvalid_i = 1'b1; bus.dreqvalid_i = 1'b1; bus.dreqaddr_i = 32'h2000;
        @(negedge clk);
`ifdef MERLIN_ARB_DPRIO_EN
        check("postrst_tie_addr", bus.mreqaddr_o, 32'h2000);
`else
        check("postrst_tie_addr", bus.mreqaddr_o, 32'h4000);
`endif
        next_cycle();
        bus.ireqvalid_i = 1'b0; bus.dreqvalid_i = 1'b0;
        repeat (3) next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
